// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin I/D cache-line arbiter in front of physical_memory.
// Define PMEM_ARB_TIMEOUT_EN to add a BUSY watchdog (TIMEOUT_CYCLES) with a DRAIN state.
module pmem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic         i_resp,
  output logic         i_error,
  output logic [255:0] i_rdata,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic         d_resp,
  output logic         d_error,
  output logic [255:0] d_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic         pmem_error,
  input  logic [255:0] pmem_rdata
);
`ifdef PMEM_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, BUSY, GAP, DRAIN} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_seen_q, err_seen_d;
`else
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif
  state_t        state_q, state_d;
  logic          last_d_q, last_d_d;
  logic          own_d_q, own_d_d;
  logic          pmem_read_q, pmem_read_d;
  logic          pmem_write_q, pmem_write_d;
  logic [31:0]   pmem_address_q, pmem_address_d;
  logic [255:0]  pmem_wdata_q, pmem_wdata_d;
  logic          i_resp_q, i_resp_d, i_error_q, i_error_d;
  logic [255:0]  i_rdata_q, i_rdata_d;
  logic          d_resp_q, d_resp_d, d_error_q, d_error_d;
  logic [255:0]  d_rdata_q, d_rdata_d;
  logic          d_req, grant_d, tmo, fin, ok;
  logic [255:0]  ret_data;
  assign d_req   = d_read | d_write;
  assign grant_d = d_req & (~i_read | ~last_d_q);
`ifdef PMEM_ARB_TIMEOUT_EN
  assign tmo = (state_q == BUSY) & ~pmem_resp & ~pmem_error & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif
  assign ok       = (state_q == BUSY) & pmem_resp;
  assign fin      = ((state_q == BUSY) & (pmem_resp | pmem_error)) | tmo;
  assign ret_data = ok ? pmem_rdata : '0;
  always_comb begin
    state_d        = state_q;
    last_d_d       = last_d_q;
    own_d_d        = own_d_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    i_resp_d       = 1'b0;
    i_error_d      = 1'b0;
    i_rdata_d      = i_rdata_q;
    d_resp_d       = 1'b0;
    d_error_d      = 1'b0;
    d_rdata_d      = d_rdata_q;
`ifdef PMEM_ARB_TIMEOUT_EN
    cnt_d          = cnt_q;
    err_seen_d     = err_seen_q;
`endif
    case (state_q)
      IDLE: if (i_read | d_req) begin
        state_d        = BUSY;
        own_d_d        = grant_d;
        last_d_d       = (i_read & d_req) ? grant_d : last_d_q;
        pmem_read_d    = ~(grant_d & d_write);
        pmem_write_d   = grant_d & d_write;
        pmem_address_d = grant_d ? d_address : i_address;
        pmem_wdata_d   = (grant_d & d_write) ? d_wdata : pmem_wdata_q;
`ifdef PMEM_ARB_TIMEOUT_EN
        cnt_d          = '0;
`endif
      end
      BUSY: begin
        state_d = (pmem_resp | pmem_error) ? GAP : BUSY;
`ifdef PMEM_ARB_TIMEOUT_EN
        cnt_d      = cnt_q + 1'b1;
        err_seen_d = 1'b0;
        state_d    = tmo ? DRAIN : state_d;
`endif
      end
      GAP: state_d = pmem_error ? GAP : IDLE;
`ifdef PMEM_ARB_TIMEOUT_EN
      DRAIN: begin
        // absorb the memory's late completion before accepting new work
        state_d    = (pmem_resp | (err_seen_q & ~pmem_error)) ? IDLE : DRAIN;
        err_seen_d = err_seen_q | pmem_error;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (fin) begin
      pmem_read_d  = 1'b0;
      pmem_write_d = 1'b0;
      i_resp_d     = ~own_d_q;
      i_error_d    = ~own_d_q & ~ok;
      i_rdata_d    = own_d_q ? i_rdata_q : ret_data;
      d_resp_d     = own_d_q;
      d_error_d    = own_d_q & ~ok;
      d_rdata_d    = own_d_q ? ret_data : d_rdata_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_d_q       <= 1'b1;
      own_d_q        <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      i_resp_q       <= 1'b0;
      i_error_q      <= 1'b0;
      i_rdata_q      <= '0;
      d_resp_q       <= 1'b0;
      d_error_q      <= 1'b0;
      d_rdata_q      <= '0;
`ifdef PMEM_ARB_TIMEOUT_EN
      cnt_q          <= '0;
      err_seen_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      last_d_q       <= last_d_d;
      own_d_q        <= own_d_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      i_resp_q       <= i_resp_d;
      i_error_q      <= i_error_d;
      i_rdata_q      <= i_rdata_d;
      d_resp_q       <= d_resp_d;
      d_error_q      <= d_error_d;
      d_rdata_q      <= d_rdata_d;
`ifdef PMEM_ARB_TIMEOUT_EN
      cnt_q          <= cnt_d;
      err_seen_q     <= err_seen_d;
`endif
    end
  end
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign i_resp       = i_resp_q;
  assign i_error      = i_error_q;
  assign i_rdata      = i_rdata_q;
  assign d_resp       = d_resp_q;
  assign d_error      = d_error_q;
  assign d_rdata      = d_rdata_q;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: scoreboard bench with a behavioural memory and per-requester expectation queues.
module tb_pmem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic         rst_n, i_read, i_resp, i_error, d_read, d_write, d_resp, d_error;
  logic [31:0]  i_address, d_address, pmem_address;
  logic [255:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
  logic         pmem_read, pmem_write, pmem_resp, pmem_error;
  pmem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_error(i_error), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_error(d_error), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_error(pmem_error), .pmem_rdata(pmem_rdata)
  );
  typedef struct packed { logic err; logic [255:0] data; } exp_t;
  exp_t         q_i[$], q_d[$];
  int           n_chk = 0, n_fail = 0;
  int           err_plan [logic [31:0]];
  logic [255:0] ref_d [logic [31:0]];
  logic [255:0] phys [logic [31:0]];
  logic         exp_tie_i = 1'b1, snap_i = 1'b0, snap_d = 1'b0;
  bit           mute = 1'b0;
  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {4{a, ~a}};
  endfunction
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic all_zero(input string name);
    chk(name, {i_resp, i_error, d_resp, d_error, pmem_read, pmem_write, pmem_address}, '0);
    chk(name, i_rdata | d_rdata | pmem_wdata, '0);
  endtask
  // side 0 = I-cache, 1 = D-cache; errn > 0 makes the memory raise pmem_error for errn cycles
  task automatic do_req(input bit side, input bit wr, input logic [31:0] a, input logic [255:0] w,
                        input int errn, input bit tog);
    exp_t e;
    int   k;
    e.err  = errn > 0;
    e.data = errn > 0 ? '0 : wr ? w : (side && ref_d.exists(a)) ? ref_d[a] : line_of(a);
    if (side && wr && errn == 0) ref_d[a] = w;
    if (errn > 0) err_plan[a] = errn;
    if (side) q_d.push_back(e); else q_i.push_back(e);
    @(negedge clk);
    if (side) begin
      d_address = a; d_wdata = w; d_read = !wr; d_write = wr;
    end else begin
      i_address = a; i_read = 1'b1;
    end
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (side ? d_resp : i_resp) break;
      if (tog) begin
        d_address = $urandom;
        d_wdata = {8{$urandom}};
      end
    end
    chk(side ? "d_resp_in_time" : "i_resp_in_time", k < 3000, 1);
    if (side) begin d_read = 1'b0; d_write = 1'b0; end else i_read = 1'b0;
  endtask
  always @(posedge clk) begin
    snap_i <= i_read;
    snap_d <= d_read | d_write;
  end
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (i_resp) begin
      chk("i_resp_cmd_low", {pmem_read, pmem_write}, '0);
      if (q_i.size() == 0) chk("i_unexpected_resp", i_resp, 0);
      else begin
        e = q_i.pop_front();
        chk("i_error", i_error, e.err);
        chk("i_rdata", i_rdata, e.data);
      end
    end
    if (d_resp) begin
      chk("d_resp_cmd_low", {pmem_read, pmem_write}, '0);
      if (q_d.size() == 0) chk("d_unexpected_resp", d_resp, 0);
      else begin
        e = q_d.pop_front();
        chk("d_error", d_error, e.err);
        chk("d_rdata", d_rdata, e.data);
      end
    end
  end
  initial begin
    int           low, lat, errn, k;
    logic [31:0]  a;
    logic [255:0] w;
    logic         wr, stab, own_i;
    low = 5; pmem_resp = 1'b0; pmem_error = 1'b0; pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!(pmem_read | pmem_write)) begin
        low++;
        continue;
      end
      chk("idle_cycle_before_grant", low >= 1, 1);
      chk("one_command", pmem_read & pmem_write, 0);
      a = pmem_address; w = pmem_wdata; wr = pmem_write;
      own_i = !wr && snap_i && a == i_address;
      if (snap_i && snap_d) begin
        chk("round_robin_i_wins", own_i, exp_tie_i);
        exp_tie_i = !own_i;
      end
      errn = err_plan.exists(a) ? err_plan[a] : 0;
      err_plan.delete(a);
      if (mute) begin
        for (k = 0; k < 200 && (pmem_read | pmem_write); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = {8{$urandom}};
        @(negedge clk);
        pmem_resp = 1'b0; low = 5;
        continue;
      end
      stab = 1'b1;
      lat = $urandom_range(1, 5);
      for (k = 0; k < lat; k++) begin
        @(negedge clk);
        if (!(pmem_read | pmem_write)) break;
        stab &= pmem_address == a && pmem_wdata == w && pmem_write == wr && pmem_read == !wr;
      end
      chk("payload_stable", stab, 1);
      if (k < lat) begin
        low = 5;
        continue;
      end
      if (errn > 0) begin
        pmem_error = 1'b1; pmem_rdata = {8{$urandom}};
        repeat (errn) begin
          @(negedge clk);
          chk("no_command_during_error", {pmem_read, pmem_write}, '0);
        end
        pmem_error = 1'b0;
      end else begin
        if (wr) phys[a] = w;
        pmem_rdata = wr ? w : phys.exists(a) ? phys[a] : line_of(a);
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("command_cleared_on_resp", {pmem_read, pmem_write}, '0);
        pmem_resp = 1'b0; pmem_rdata = {8{$urandom}};
      end
      low = 0;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    all_zero("reset_outputs");
    rst_n = 1'b1;
    do_req(0, 0, 32'h40, '0, 0, 0);
    repeat (2) fork
      do_req(0, 0, 32'h240, '0, 0, 0);
      do_req(1, 1, 32'h0010_0040, {8{$urandom}}, 0, 0);
    join
    do_req(1, 1, 32'h100, '1, 0, 1);
    do_req(1, 0, 32'h100, '0, 0, 0);
    fork
      do_req(0, 0, 32'h60, '0, 5, 0);
      begin @(negedge clk); do_req(1, 0, 32'h0010_0040, '0, 0, 0); end
    join
    begin
      int k;
      @(negedge clk);
      i_address = 32'hA0; i_read = 1'b1;
      for (k = 0; k < 100 && !pmem_read; k++) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; i_read = 1'b0;
      all_zero("reset_mid_transaction");
      exp_tie_i = 1'b1;
      repeat (5) @(negedge clk);
    end
    do_req(0, 0, 32'hC0, '0, 0, 0);
`ifdef PMEM_ARB_TIMEOUT_EN
    mute = 1'b1;
    fork
      do_req(0, 0, 32'h80, '0, 1, 0);
      begin
        int k;
        for (k = 0; k < 100 && !pmem_read; k++) @(negedge clk);
        for (k = 0; k < 100 && !i_resp; k++) @(negedge clk);
        chk("timeout_latency", k, 8);
      end
    join
    mute = 1'b0;
    repeat (8) @(negedge clk);
    do_req(0, 0, 32'hE0, '0, 0, 0);
`endif
    fork
      for (int n = 0; n < 40; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_req(0, 0, 32'($urandom_range(0, 255)) << 5, '0,
               $urandom_range(0, 9) == 0 ? int'($urandom_range(1, 3)) : 0, 0);
      end
      for (int n = 0; n < 40; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_req(1, 1'($urandom_range(0, 1)), 32'h0010_0000 | (32'($urandom_range(0, 7)) << 5),
               {8{$urandom}}, $urandom_range(0, 9) == 0 ? int'($urandom_range(1, 3)) : 0, 0);
      end
    join
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", q_i.size() + q_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-port initiator in front of `physical_memory`. It arbitrates 256-bit cache-line requests from the instruction cache (read-only) and the data cache (read/write) onto the single physical-memory port. It registers and holds address, data and command stable for the whole transaction, which the memory's change-detection check requires. It returns each response or error to the requester that owns the transaction.

## Interface
- `TIMEOUT_CYCLES`, 1024: watchdog limit in cycles of `BUSY`. Only used when `PMEM_ARB_TIMEOUT_EN` is defined.
- `clk  in  1`: single clock, all logic on posedge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `i_read  in  1`: I-cache read request, level, held until `i_resp`.
- `i_address  in  32`: I-cache line address.
- `i_resp  out  1`: one-cycle completion pulse to the I-cache.
- `i_error  out  1`: valid with `i_resp`; transaction failed.
- `i_rdata  out  256`: line data, valid with `i_resp`.
- `d_read  in  1`, `d_write  in  1`: D-cache request, level, mutually exclusive.
- `d_address  in  32`: D-cache line address.
- `d_wdata  in  256`: D-cache write line.
- `d_resp  out  1`, `d_error  out  1`, `d_rdata  out  256`: as the I-side outputs.
- `pmem_read  out  1`, `pmem_write  out  1`: command to memory.
- `pmem_address  out  32`, `pmem_wdata  out  256`: memory request payload.
- `pmem_resp  in  1`, `pmem_error  in  1`, `pmem_rdata  in  256`: memory response.

## Operation
- All outputs are registered.
- Reset values: every output is 0, state is `IDLE`, `last_grant` = D (so the I-side wins the first tie).
- `IDLE` → `BUSY`: a request is sampled and granted.
  - Only one requester active: that side is granted.
  - Both active: round-robin. The side not in `last_grant` is granted, and `last_grant` updates.
  - On grant, latch the address, the wdata (D write only) and the command into the `pmem_*` registers, and record the owner.
- `BUSY`: the `pmem_*` outputs are frozen. The requester's inputs are ignored for the rest of the transaction.
- `BUSY`, `pmem_resp`=1:
  - Clear `pmem_read`/`pmem_write`.
  - Copy `pmem_rdata` into the owner's rdata.
  - Pulse the owner's resp for one cycle; error=0.
  - Go to `GAP`.
  - A write also returns `pmem_rdata`, which holds the written line.
- `BUSY`, `pmem_error`=1 (`pmem_resp`=0):
  - Clear the command.
  - Pulse the owner's resp and error; owner's rdata = 0.
  - Go to `GAP`.
- `GAP`: command stays low.
  - Returns to `IDLE` on the first cycle with `pmem_error`=0.
  - This gives at least one idle cycle between transactions, so the memory's respond state is never overlapped by a new command.
- The non-owner's resp/error/rdata are never driven during another side's transaction.
- `d_read` and `d_write` both high is illegal. The arbiter treats it as a write and is not required to flag it.
- `rst_n` low in any state: synchronous return to the reset values at the next edge. A transaction in flight is dropped without a response.

## Timing
- Grant: request sampled at edge E0 → `pmem_read`/`pmem_write` high from E0.
- Completion: `pmem_resp` or `pmem_error` sampled at edge Ek → owner resp high for exactly cycle Ek..Ek+1, with the command already low.
- Back-to-back: after GAP→IDLE at edge Ek+1, the earliest next grant is at edge Ek+2.
- Minimum occupancy: 3 cycles per transaction beyond the memory latency.
- Requesters must drop their request on the cycle after their resp, or they are re-granted.

## Configuration
- `PMEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on grant and increments each `BUSY` cycle.
  - Reaching `TIMEOUT_CYCLES` aborts: command cleared, owner gets resp=1, error=1, rdata=0, and the state goes to `DRAIN`.
  - `DRAIN` → `IDLE` on `pmem_resp`, or on `pmem_error` falling after having been high. This absorbs the memory's late completion.
- `PMEM_ARB_TIMEOUT_EN` not defined: no counter, no `DRAIN` state, and `BUSY` waits indefinitely.

## Test plan
- **Single I read.** `i_read`, `i_address`=0x0000_0040 against the 250 ns memory → one `pmem_read` transaction at 0x40, one `i_resp` pulse, `i_rdata` equals the memory line, `i_error`=0, `d_resp` never high.
- **Simultaneous requests.** `i_read` and `d_write` rise on the same edge after reset → I-side granted first, D write issued at least 2 cycles after `i_resp`. A second collision grants D first.
- **Payload stability.** `d_write` 0x100 with `d_wdata`=all-ones; the bench toggles `d_address` during `BUSY` → `pmem_address`/`pmem_wdata` stay constant, memory never reports "Invalid input", readback of 0x100 is all-ones.
- **Error path.** Force `pmem_error`=1 for 5 cycles in `BUSY` → owner resp=1, error=1, rdata=0. No new command until `pmem_error` is low.
- **Reset mid-transaction.** `rst_n`=0 for 1 cycle during `BUSY` → all outputs 0 at the next edge, no resp pulse, and the next request is granted normally.
- **Timeout (macro on, `TIMEOUT_CYCLES`=8, memory never responds).** Resp with error=1 exactly 8 cycles after grant, state `DRAIN`; a later `pmem_resp` returns the arbiter to `IDLE` with no extra resp.
